// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the run sequencer.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int DEF_CYC_W   = 16;
    localparam int DEF_TIMEOUT = 60000;
    localparam int DEF_RST_CYC = 2;

endpackage

// File: rtl/run_ctrl_if.sv
// Request and result handshakes between a requester (master) and run_ctrl (slave).
// Both channels: a transfer happens on a rising edge where valid && ready are both high.
interface run_ctrl_if #(
    parameter int CYC_W = 16
);
    logic             go_valid;
    logic             go_ready;
    logic             res_valid;
    logic             res_ready;
    logic [CYC_W-1:0] res_cycles;
    logic             res_timeout;

    modport master (
        output go_valid,
        input  go_ready,
        input  res_valid,
        output res_ready,
        input  res_cycles,
        input  res_timeout
    );

    modport slave (
        input  go_valid,
        output go_ready,
        output res_valid,
        input  res_ready,
        output res_cycles,
        output res_timeout
    );
endinterface

// File: rtl/run_ctrl_cnt.sv
// Up-counter with synchronous clear (priority) and enable, asynchronous reset.
module run_ctrl_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: holds the core in reset, releases it, times the run until done
// or timeout, and hands back the cycle count over a valid/ready result channel.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CYC_W   = DEF_CYC_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int RST_CYC = DEF_RST_CYC
) (
    input  logic             clk,
    input  logic             rst,
    run_ctrl_if.slave        bus,
    output logic             start,
    input  logic             done,
    output logic             busy,
    output state_t           state_dbg
);

    localparam logic [CYC_W-1:0] ARM_LAST = CYC_W'(RST_CYC - 1);
    localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [CYC_W-1:0] TMO_VAL  = CYC_W'(TIMEOUT);

    state_t           state;
    logic [CYC_W-1:0] cnt;
    logic             cnt_clr;
    logic             cnt_en;
    logic             arm_last;
    logic             res_valid_q;
    logic [CYC_W-1:0] res_cycles_q;
    logic             res_timeout_q;

    // One counter times ARM and then RUN; it is re-cleared at each hand-over.
    assign arm_last = (state == ARM) && (cnt == ARM_LAST);
    assign cnt_clr  = (state == IDLE) || arm_last;
    assign cnt_en   = (state == ARM) || (state == RUN);

    run_ctrl_cnt #(.W(CYC_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .q   (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            start         <= 1'b0;
            res_valid_q   <= 1'b0;
            res_cycles_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go_valid) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (arm_last) begin
                        state <= RUN;
                        start <= 1'b1;
                    end
                end
                RUN: begin
                    // done takes precedence over a timeout landing in the same cycle
                    if (done) begin
                        state         <= REPORT;
                        start         <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_cycles_q  <= cnt + 1'b1;
                        res_timeout_q <= 1'b0;
                    end else if (cnt == TMO_LAST) begin
                        state         <= REPORT;
                        start         <= 1'b0;
                        res_valid_q   <= 1'b1;
                        res_cycles_q  <= TMO_VAL;
                        res_timeout_q <= 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    start <= 1'b0;
                end
            endcase
        end
    end

    assign bus.go_ready    = (state == IDLE);
    assign bus.res_valid   = res_valid_q;
    assign bus.res_cycles  = res_cycles_q;
    assign bus.res_timeout = res_timeout_q;
    assign busy            = (state != IDLE);
    assign state_dbg       = state;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed testbench for run_ctrl with a behavioural core model driving done.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    logic   clk;
    logic   rst;
    logic   start;
    logic   done;
    logic   busy;
    state_t state_dbg;

    int     checks;
    int     errors;
    int     rn;
    int     done_at;
    logic   done_force;

    run_ctrl_if #(.CYC_W(16)) bus ();

    run_ctrl #(.CYC_W(16), .TIMEOUT(100), .RST_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // core model: rn = completed run cycles; done is high from run cycle done_at on
    always @(posedge clk) rn <= start ? rn + 1 : 0;
    assign done = done_force | ((done_at != 0) && start && (rn + 1 >= done_at));

    // driver: accept a request, count low cycles before start, then high cycles
    task automatic run_once(output int arm_lo, output int hi, output bit hung);
        int guard;
        arm_lo = 0;
        hi     = 0;
        hung   = 1'b0;
        bus.go_valid = 1'b1;
        @(negedge clk);
        bus.go_valid = 1'b0;
        guard = 0;
        while (start !== 1'b1 && guard < 20) begin
            arm_lo++;
            guard++;
            @(negedge clk);
        end
        guard = 0;
        while (start === 1'b1 && guard < 400) begin
            hi++;
            guard++;
            @(negedge clk);
        end
        if (start === 1'b1 || arm_lo >= 20) hung = 1'b1;
    endtask

    task automatic res_handshake();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || bus.go_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: start=%b go_ready=%b busy=%b, want 0 1 0", start, bus.go_ready, busy);
        end
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_cycles !== 16'd0 || bus.res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_res: valid=%b cycles=%0d tmo=%b, want 0 0 0",
                     bus.res_valid, bus.res_cycles, bus.res_timeout);
        end
    endtask

    task automatic test_normal();
        int lo, hi;
        bit hung;
        done_at = 37;
        run_once(lo, hi, hung);
        checks++;
        if (hung || hi !== 37) begin
            errors++;
            $display("FAIL normal_start_len: got %0d hung=%0b, want 37", hi, hung);
        end
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_cycles !== 16'd37 || bus.res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL normal_result: valid=%b cycles=%0d tmo=%b, want 1 37 0",
                     bus.res_valid, bus.res_cycles, bus.res_timeout);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (start !== 1'b0 || state_dbg !== REPORT) begin
            errors++;
            $display("FAIL normal_report_hold: start=%b state=%0d, want 0 %0d", start, state_dbg, REPORT);
        end
        res_handshake();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.go_ready !== 1'b1 || bus.res_cycles !== 16'd37) begin
            errors++;
            $display("FAIL normal_release: valid=%b go_ready=%b cycles=%0d, want 0 1 37",
                     bus.res_valid, bus.go_ready, bus.res_cycles);
        end
        done_at = 0;
    endtask

    task automatic test_reset_mid_run();
        done_at = 0;
        bus.go_valid = 1'b1;
        @(negedge clk);
        bus.go_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL midrun_setup: start=%b, want 1", start);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async_drop: start=%b busy=%b, want 0 0", start, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (start !== 1'b0 || bus.go_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_cycles !== 16'd0) begin
            errors++;
            $display("FAIL midrun_after: start=%b go_ready=%b valid=%b cycles=%0d, want 0 1 0 0",
                     start, bus.go_ready, bus.res_valid, bus.res_cycles);
        end
    endtask

    task automatic test_timeout();
        int lo, hi;
        bit hung;
        done_at = 0;
        run_once(lo, hi, hung);
        checks++;
        if (hung || hi !== 100) begin
            errors++;
            $display("FAIL timeout_start_len: got %0d hung=%0b, want 100", hi, hung);
        end
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_cycles !== 16'd100 || bus.res_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: valid=%b cycles=%0d tmo=%b, want 1 100 1",
                     bus.res_valid, bus.res_cycles, bus.res_timeout);
        end
        res_handshake();
    endtask

    task automatic test_tie();
        int lo, hi;
        bit hung;
        done_at = 100;
        run_once(lo, hi, hung);
        checks++;
        if (hung || bus.res_cycles !== 16'd100 || bus.res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tie_result: cycles=%0d tmo=%b hung=%0b, want 100 0", bus.res_cycles, bus.res_timeout, hung);
        end
        res_handshake();
        done_at = 0;
    endtask

    task automatic test_backpressure();
        int lo, hi, bad, guard;
        bit hung;
        done_at = 5;
        run_once(lo, hi, hung);
        bus.go_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.res_valid !== 1'b1 || bus.res_cycles !== 16'd5 || bus.res_timeout !== 1'b0 ||
                bus.go_ready !== 1'b0 || state_dbg !== REPORT) bad++;
            @(negedge clk);
        end
        checks++;
        if (hung || bad !== 0) begin
            errors++;
            $display("FAIL bp_stable: bad cycles=%0d hung=%0b, want 0", bad, hung);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || state_dbg !== IDLE || bus.go_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_handshake: valid=%b state=%0d go_ready=%b, want 0 %0d 1",
                     bus.res_valid, state_dbg, bus.go_ready, IDLE);
        end
        @(negedge clk);
        bus.go_valid = 1'b0;
        checks++;
        if (state_dbg !== ARM) begin
            errors++;
            $display("FAIL bp_accept: state=%0d, want %0d", state_dbg, ARM);
        end
        guard = 0;
        while (bus.res_valid !== 1'b1 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (bus.res_cycles !== 16'd5 || bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_run: valid=%b cycles=%0d, want 1 5", bus.res_valid, bus.res_cycles);
        end
        res_handshake();
        done_at = 0;
    endtask

    task automatic test_stray_done();
        int lo, hi;
        bit hung;
        done_force = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state_dbg !== IDLE || start !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: state=%0d start=%b valid=%b, want %0d 0 0",
                     state_dbg, start, bus.res_valid, IDLE);
        end
        run_once(lo, hi, hung);
        checks++;
        if (lo !== 2) begin
            errors++;
            $display("FAIL stray_arm_len: start low %0d cycles, want 2", lo);
        end
        checks++;
        if (hung || hi !== 1 || bus.res_cycles !== 16'd1 || bus.res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL stray_result: hi=%0d cycles=%0d tmo=%b, want 1 1 0", hi, bus.res_cycles, bus.res_timeout);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (state_dbg !== REPORT || bus.res_cycles !== 16'd1) begin
            errors++;
            $display("FAIL stray_report: state=%0d cycles=%0d, want %0d 1", state_dbg, bus.res_cycles, REPORT);
        end
        res_handshake();
        done_force = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        done_at      = 0;
        done_force   = 1'b0;
        bus.go_valid = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_normal();
        test_reset_mid_run();
        test_timeout();
        test_tie();
        test_backpressure();
        test_stray_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
